// File: rtl/regfile_clearing.sv
// MIPS-style 2-read/1-write register file with r0 hardwired to zero.
// After reset a sequencer zeroes r1..rN-1, one per clock, before raising Ready.
module regfile_clearing #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned BYPASS    = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [ADDR_BITS-1:0] ReadRegister1,
  input  logic [ADDR_BITS-1:0] ReadRegister2,
  input  logic [ADDR_BITS-1:0] WriteRegister,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic                 RegWrite,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2,
  output logic                 Ready
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_REGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t               state_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 ready_q;
  logic [WIDTH-1:0]     mem_q [NUM_REGS];

  // Sequencer and array share one clocked process so CLEAR and RUN writes never collide.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= CLEAR;
      idx_q   <= ADDR_BITS'(1);
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          mem_q[idx_q] <= '0;
          if (idx_q == LAST_IDX) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_BITS'(1);
          end
        end
        RUN: begin
          if (RegWrite && (WriteRegister != '0)) begin
            mem_q[WriteRegister] <= WriteData;
          end
        end
        default: begin
          state_q <= CLEAR;
          idx_q   <= ADDR_BITS'(1);
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Reads are blanked until the clear finishes; r0 is never stored, only decoded.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_BITS-1:0] addr);
    logic [WIDTH-1:0] data;
    data = '0;
    if ((state_q == RUN) && (addr != '0)) begin
      data = mem_q[addr];
      if ((BYPASS != 0) && RegWrite && (WriteRegister == addr)) begin
        data = WriteData;
      end
    end
    return data;
  endfunction

  always_comb begin
    ReadData1 = read_port(ReadRegister1);
    ReadData2 = read_port(ReadRegister2);
  end

  assign Ready = ready_q;

endmodule

// File: tb/tb_regfile_clearing.sv
// Bench for regfile_clearing: a BYPASS=0 and a BYPASS=1 instance share the inputs
// and are both compared against an array model of the register file.
module tb_regfile_clearing;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [4:0]  ReadRegister1 = '0, ReadRegister2 = '0, WriteRegister = '0;
  logic [31:0] WriteData = '0;
  logic        RegWrite = 1'b0;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        rdy_a, rdy_b;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: register contents, clear-progress counter, ready flag.
  logic [31:0] model [32];
  int          clr_edges = 0;
  bit          m_ready = 1'b0;

  always #5 Clk = ~Clk;

  regfile_clearing #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(0)) dut (
    .Clk(Clk), .Reset(Reset), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd1_a), .ReadData2(rd2_a), .Ready(rdy_a));

  regfile_clearing #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(1)) dut_byp (
    .Clk(Clk), .Reset(Reset), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(rd1_b), .ReadData2(rd2_b), .Ready(rdy_b));

  // Expected read value for the current inputs; byp selects the forwarding build.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!m_ready || a == 5'd0) return 32'd0;
    if (byp && RegWrite && WriteRegister == a) return WriteData;
    return model[a];
  endfunction

  // One clock edge: advance the model with the values the DUT samples, then settle.
  task automatic tick();
    @(posedge Clk);
    if (Reset) begin
      m_ready   = 1'b0;
      clr_edges = 0;
    end else if (!m_ready) begin
      clr_edges++;
      if (clr_edges == 31) begin
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
      end
    end else if (RegWrite && WriteRegister != 5'd0) begin
      model[WriteRegister] = WriteData;
    end
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1; WriteRegister = a; WriteData = d;
    tick();
    RegWrite = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      ReadRegister1 = 5'($urandom_range(0, 31));
      ReadRegister2 = 5'($urandom_range(0, 31));
      #1;
      n_cmp++;
      if (rdy_a !== 1'b0 || rd1_a !== 32'd0 || rd2_b !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_clear edge %0d: ready=%b rd1=%h rd2b=%h, required 0/0/0", e, rdy_a, rd1_a, rd2_b);
      end
      tick();
      n_cmp++;
      if (rdy_a !== m_ready || rdy_b !== m_ready) begin
        n_fail++;
        $display("FAIL ready_timing after edge %0d: got %b/%b, required %b", e, rdy_a, rdy_b, m_ready);
      end
    end
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = 5'(a); ReadRegister2 = 5'(31 - a);
      #1;
      n_cmp++;
      if (rd1_a !== 32'd0 || rd2_a !== 32'd0 || rd1_b !== 32'd0 || rd2_b !== 32'd0) begin
        n_fail++;
        $display("FAIL cleared_read r%0d: got %h %h %h %h, required 0", a, rd1_a, rd2_a, rd1_b, rd2_b);
      end
    end
  endtask

  task automatic test_write_r2();
    logic [31:0] vals [2];
    vals[0] = 32'd42; vals[1] = 32'd15;
    ReadRegister1 = 5'd2; ReadRegister2 = 5'd2;
    for (int k = 0; k < 2; k++) begin
      do_write(5'd2, vals[k]);
      n_cmp++;
      if (rd1_a !== vals[k] || rd2_a !== vals[k] || rd1_b !== vals[k] || rd2_b !== vals[k]) begin
        n_fail++;
        $display("FAIL write_r2 #%0d: got %0d %0d %0d %0d, required %0d", k, rd1_a, rd2_a, rd1_b, rd2_b, vals[k]);
      end
    end
  endtask

  task automatic test_no_write();
    RegWrite = 1'b0; WriteRegister = 5'd2; WriteData = 32'd150;
    tick();
    ReadRegister1 = 5'd2; ReadRegister2 = 5'd10;
    #1;
    n_cmp++;
    if (rd1_a !== 32'd15 || rd1_b !== 32'd15 || rd2_a !== 32'd0 || rd2_b !== 32'd0) begin
      n_fail++;
      $display("FAIL regwrite_off: r2=%0d/%0d r10=%0d/%0d, required 15 and 0", rd1_a, rd1_b, rd2_a, rd2_b);
    end
  endtask

  task automatic test_r0_and_ports();
    do_write(5'd0, 32'd1234);
    do_write(5'd17, 32'd1);
    do_write(5'd16, 32'd1111);
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    #1;
    n_cmp++;
    if (rd1_a !== 32'd0 || rd2_b !== 32'd0) begin
      n_fail++;
      $display("FAIL r0_write: got %0d/%0d, required 0", rd1_a, rd2_b);
    end
    for (int s = 0; s < 2; s++) begin
      ReadRegister1 = (s == 0) ? 5'd17 : 5'd16;
      ReadRegister2 = (s == 0) ? 5'd16 : 5'd17;
      #1;
      n_cmp++;
      if (rd1_a !== exp_rd(ReadRegister1, 0) || rd2_a !== exp_rd(ReadRegister2, 0) ||
          rd1_a !== ((s == 0) ? 32'd1 : 32'd1111) || rd2_b !== ((s == 0) ? 32'd1111 : 32'd1)) begin
        n_fail++;
        $display("FAIL port_pair swap=%0d: got %0d %0d, required %0d %0d", s, rd1_a, rd2_b,
                 (s == 0) ? 1 : 1111, (s == 0) ? 1111 : 1);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i * 3));
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
      #1;
      n_cmp++;
      if (rd1_a !== 32'(i * 3) || rd2_a !== 32'((31 - i) * 3) ||
          rd1_b !== 32'(i * 3) || rd2_b !== 32'((31 - i) * 3)) begin
        n_fail++;
        $display("FAIL fill_pair (%0d,%0d): got %0d %0d, required %0d %0d", i, 31 - i, rd1_a, rd2_a,
                 i * 3, (31 - i) * 3);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      RegWrite      = 1'($urandom_range(0, 1));
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData     = $urandom;
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = 5'($urandom_range(0, 31));
      #1;
      n_cmp++;
      if (rd1_a !== exp_rd(ReadRegister1, 0) || rd2_a !== exp_rd(ReadRegister2, 0) ||
          rd1_b !== exp_rd(ReadRegister1, 1) || rd2_b !== exp_rd(ReadRegister2, 1)) begin
        n_fail++;
        $display("FAIL random #%0d rr1=%0d rr2=%0d: got %h %h %h %h, required %h %h %h %h", n,
                 ReadRegister1, ReadRegister2, rd1_a, rd2_a, rd1_b, rd2_b,
                 exp_rd(ReadRegister1, 0), exp_rd(ReadRegister2, 0),
                 exp_rd(ReadRegister1, 1), exp_rd(ReadRegister2, 1));
      end
      tick();
    end
    RegWrite = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    int edges;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int e = 1; e <= 9; e++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    edges = 0;
    for (int e = 1; e <= 40 && !rdy_a; e++) begin
      RegWrite = 1'b1;
      WriteRegister = 5'($urandom_range(1, 31));
      WriteData = $urandom | 32'h1;
      ReadRegister1 = WriteRegister;
      ReadRegister2 = 5'($urandom_range(0, 31));
      #1;
      n_cmp++;
      if (rd1_a !== 32'd0 || rd1_b !== 32'd0 || rd2_b !== 32'd0) begin
        n_fail++;
        $display("FAIL clear_reads edge %0d: got %h %h %h, required 0", e, rd1_a, rd1_b, rd2_b);
      end
      tick();
      edges = e;
    end
    RegWrite = 1'b0;
    n_cmp++;
    if (edges !== 31 || rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL reready_edges: ready=%b/%b after %0d edges, required 1 after 31", rdy_a, rdy_b, edges);
    end
    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = 5'(a); ReadRegister2 = 5'(a);
      #1;
      n_cmp++;
      if (rd1_a !== 32'd0 || rd2_b !== 32'd0) begin
        n_fail++;
        $display("FAIL clear_dropped_write r%0d: got %h/%h, required 0", a, rd1_a, rd2_b);
      end
    end
  endtask

  task automatic test_bypass();
    do_write(5'd5, 32'd9);
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'd77;
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
    #1;
    n_cmp++;
    if (rd1_b !== 32'd77 || rd1_a !== 32'd9) begin
      n_fail++;
      $display("FAIL bypass_pre_edge: byp=%0d nobyp=%0d, required 77 and 9", rd1_b, rd1_a);
    end
    tick();
    RegWrite = 1'b0;
    #1;
    n_cmp++;
    if (rd1_a !== 32'd77 || rd2_a !== 32'd77 || rd1_b !== 32'd77) begin
      n_fail++;
      $display("FAIL bypass_post_edge: got %0d %0d %0d, required 77", rd1_a, rd2_a, rd1_b);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_write_r2();
    test_no_write();
    test_r0_and_ports();
    test_fill();
    test_random();
    test_reset_mid_clear();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
